// File: rtl/dmem_responder.sv
// Data-memory slave: one request at a time, byte-lane-masked stores, aligned doubleword loads, fixed wait states.
// Optional DMEM_LFSR_DELAY_EN adds 0..3 pseudo-random extra wait cycles per request.
module dmem_responder #(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_dwhb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state;
    logic [4:0]     cnt;
    logic [4:0]     lat_load;
    logic           wen_q;
    logic           err_q;
    logic [AW-1:0]  idx_q;
    logic [7:0]     strb_q;
    logic [63:0]    wdat_q;
    logic [63:0]    mem [DEPTH];

    logic [63:0]    rel;
    logic [2:0]     off;
    logic [7:0]     base_mask;
    logic           size_err;
    logic           align_err;
    logic           range_err;
    logic           commit;

    always_comb begin
        rel       = req_addr - BASE_ADDR;
        off       = req_addr[2:0];
        base_mask = 8'h00;
        size_err  = 1'b0;
        align_err = 1'b0;
        case (req_dwhb)
            4'b0001: base_mask = 8'h01;
            4'b0010: begin base_mask = 8'h03; align_err = off[0];    end
            4'b0100: begin base_mask = 8'h0F; align_err = |off[1:0]; end
            4'b1000: begin base_mask = 8'hFF; align_err = |off;      end
            default: size_err = 1'b1;
        endcase
        range_err = (req_addr < BASE_ADDR) || (rel >= SPAN);
    end

`ifdef DMEM_LFSR_DELAY_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 8'h5A;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign lat_load = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
    assign lat_load = 5'(LATENCY);
`endif

    // The access edge is always a WAIT-state edge, so LATENCY=0 still yields one cycle after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wen_q     <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            strb_q    <= '0;
            wdat_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wen_q     <= req_wen;
                        err_q     <= size_err | align_err | range_err;
                        idx_q     <= rel[AW+2:3];
                        strb_q    <= base_mask << off;
                        wdat_q    <= req_wdata << {off, 3'b000};
                        cnt       <= lat_load;
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 5'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                        rsp_rdata <= (wen_q || err_q) ? 64'd0 : mem[idx_q];
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset forces state to IDLE asynchronously, so an uncommitted store can never land.
    assign commit = (state == WAIT) && (cnt == 5'd0) && wen_q && !err_q;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 8; b++) begin
                if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
            end
        end
    end
endmodule
